bram_port_arbiter: RTL
======================

// Module: bram_port_arbiter
// PURPOSE
//   Shares one single-port BRAM (32-bit row, 1-cycle read latency) between two requesters:
//   port 0 = host/loader (fills BRAM0 rows), port 1 = accumulator read engine.
//   Round-robin arbitration with burst hold, per-port read-return steering.
//   Sits between the requesters and the BRAM0 Memory I/F (addr/ce/we/d/q).
// PARAMETERS
//   AWIDTH     8    BRAM address width
//   DWIDTH     32   BRAM data width (4 x 8-bit numbers per row)
//   MAX_BURST  16   accepted accesses an owner may chain before yielding to a waiting port (>=1)
// PORTS
//   clk        in   1       single clock, all logic on posedge
//   reset      in   1       synchronous, active-high reset
//   req0_i     in   1       port 0 access request (held until granted)
//   we0_i      in   1       port 0 write enable (1 = write, 0 = read)
//   addr0_i    in   AWIDTH  port 0 address
//   d0_i       in   DWIDTH  port 0 write data
//   gnt0_o     out  1       port 0 grant; access accepted in cycle where req0_i & gnt0_o
//   rvalid0_o  out  1       port 0 read data valid on rdata_o
//   req1_i / we1_i / addr1_i / d1_i / gnt1_o / rvalid1_o   same, for port 1
//   rdata_o    out  DWIDTH  read data, = q_i (shared, qualify with rvalidN_o)
//   addr_o     out  AWIDTH  BRAM address
//   ce_o       out  1       BRAM chip enable
//   we_o       out  1       BRAM write enable
//   d_o        out  DWIDTH  BRAM write data
//   q_i        in   DWIDTH  BRAM read data (valid 1 cycle after ce_o & !we_o)
//   busy_o     out  1       1 when state != IDLE
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-high.
//   State: IDLE, OWN0, OWN1; regs burst_cnt (0..MAX_BURST, saturating), rr_ptr (port favoured on tie).
//   Grant (combinational from state + reqs; at most one gntN_o high):
//     IDLE: both req -> port rr_ptr; one req -> that port; none -> no grant.
//     OWNx: req_x & !(burst_cnt==MAX_BURST & req_other) -> gnt_x;
//           else req_other -> gnt_other (switch, zero dead cycles); else none.
//   Update on clk: grant to y -> state<=OWNy; burst_cnt<=(y==owner)?sat(burst_cnt+1):1;
//     if arbitration chose y over a requesting other port, rr_ptr<=other.
//     No grant -> state<=IDLE, burst_cnt<=0, rr_ptr unchanged.
//   BRAM drive (combinational mux of granted port): ce_o=1, we_o=weN_i, addr_o=addrN_i, d_o=dN_i.
//     No grant: ce_o=0, we_o=0, addr_o=0, d_o=0.
//   Read return: accepted read at cycle N -> rvalidN_o=1 at cycle N+1 (registered), rdata_o=q_i.
//     Writes never produce rvalid. Back-to-back reads give back-to-back rvalid.
//   Switch boundary: port 0 read at N, port 1 read at N+1 -> rvalid0_o at N+1, rvalid1_o at N+2.
//   Single requester never starved by itself: burst_cnt saturates, owner keeps grant.
//   Simultaneous req rise both ports from IDLE: rr_ptr decides; reset value rr_ptr=0.
//   Reset (anytime, incl. mid-burst): state=IDLE, burst_cnt=0, rr_ptr=0, rvalid0_o=rvalid1_o=0
//     (pending read returns dropped), busy_o=0; combinational outputs follow (no grants in reset cycle).
// CONFIGURATION
//   ARB_STAT_EN defined: adds ports stat_clr_i (in,1), wait0_cnt_o / wait1_cnt_o (out,16):
//     count cycles with reqN_i=1 & gntN_o=0, saturate at 16'hFFFF; stat_clr_i=1 -> both 0 next
//     cycle (clear wins over increment); reset -> 0.
//   ARB_STAT_EN undefined: ports and counters absent; arbitration identical.
// TESTING
//   1. Reset, port 0 writes 4 rows addr 0..3 data 32'h04030201.. -> gnt0 4 cycles, ce/we=1, no rvalid.
//   2. Port 1 alone reads addr 0..3 -> rvalid1 cycles N+1..N+4, rdata = written rows, busy_o=1 then 0.
//   3. Both req continuously, MAX_BURST=16 -> grants alternate in blocks of 16, first block port 0.
//   4. Port 1 drops req mid-burst while port 0 waits -> port 0 granted next cycle, no idle gap.
//   5. reset pulse 1 cycle after accepted read -> rvalid stays 0, state IDLE, next grant rr_ptr=0.
//   6. ARB_STAT_EN: port 0 waits 16 cycles during port 1 burst -> wait0_cnt_o=16; stat_clr_i -> 0.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between a loader (port 0) and a read engine (port 1).
// Optional per-port wait-cycle statistics are enabled with `define ARB_STAT_EN.
module bram_port_arbiter #(
  parameter int AWIDTH    = 8,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
`ifdef ARB_STAT_EN
  input  logic              stat_clr_i,
  output logic [15:0]       wait0_cnt_o,
  output logic [15:0]       wait1_cnt_o,
`endif
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [AWIDTH-1:0] addr0_i,
  input  logic [DWIDTH-1:0] d0_i,
  output logic              gnt0_o,
  output logic              rvalid0_o,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [AWIDTH-1:0] addr1_i,
  input  logic [DWIDTH-1:0] d1_i,
  output logic              gnt1_o,
  output logic              rvalid1_o,
  output logic [DWIDTH-1:0] rdata_o,
  output logic [AWIDTH-1:0] addr_o,
  output logic              ce_o,
  output logic              we_o,
  output logic [DWIDTH-1:0] d_o,
  input  logic [DWIDTH-1:0] q_i,
  output logic              busy_o
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic          rvalid0_q, rvalid1_q;
  logic          gnt0, gnt1, at_max;
  logic [BW-1:0] burst_inc;

  assign at_max    = (burst_cnt_q == BMAX);
  assign burst_inc = at_max ? BMAX : burst_cnt_q + 1'b1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_i && req1_i) begin
          gnt0 = ~rr_ptr_q;
          gnt1 = rr_ptr_q;
        end else begin
          gnt0 = req0_i;
          gnt1 = req1_i;
        end
      end
      OWN0: begin
        if (req0_i && !(at_max && req1_i)) gnt0 = 1'b1;
        else if (req1_i)                   gnt1 = 1'b1;
      end
      OWN1: begin
        if (req1_i && !(at_max && req0_i)) gnt1 = 1'b1;
        else if (req0_i)                   gnt0 = 1'b1;
      end
      default: ;
    endcase
    // Nothing is granted while reset is being applied.
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    state_d     = IDLE;
    burst_cnt_d = '0;
    rr_ptr_d    = rr_ptr_q;
    if (gnt0) begin
      state_d     = OWN0;
      burst_cnt_d = (state_q == OWN0) ? burst_inc : BW'(1);
      if (req1_i) rr_ptr_d = 1'b1;
    end else if (gnt1) begin
      state_d     = OWN1;
      burst_cnt_d = (state_q == OWN1) ? burst_inc : BW'(1);
      if (req0_i) rr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      rr_ptr_q    <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      rvalid0_q   <= gnt0 & ~we0_i;
      rvalid1_q   <= gnt1 & ~we1_i;
    end
  end

  assign gnt0_o    = gnt0;
  assign gnt1_o    = gnt1;
  assign ce_o      = gnt0 | gnt1;
  assign we_o      = gnt0 ? we0_i   : (gnt1 ? we1_i   : 1'b0);
  assign addr_o    = gnt0 ? addr0_i : (gnt1 ? addr1_i : '0);
  assign d_o       = gnt0 ? d0_i    : (gnt1 ? d1_i    : '0);
  assign rdata_o   = q_i;
  // A return in flight when reset arrives is dropped in the same cycle.
  assign rvalid0_o = rvalid0_q & ~reset;
  assign rvalid1_o = rvalid1_q & ~reset;
  assign busy_o    = (state_q != IDLE) & ~reset;

`ifdef ARB_STAT_EN
  logic [15:0] wait0_q, wait1_q;

  always_ff @(posedge clk) begin
    if (reset || stat_clr_i) begin
      wait0_q <= '0;
      wait1_q <= '0;
    end else begin
      if (req0_i && !gnt0 && wait0_q != 16'hFFFF) wait0_q <= wait0_q + 16'd1;
      if (req1_i && !gnt1 && wait1_q != 16'hFFFF) wait1_q <= wait1_q + 16'd1;
    end
  end

  assign wait0_cnt_o = wait0_q;
  assign wait1_cnt_o = wait1_q;
`endif

endmodule
